// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding and sizing helpers for the pong game controller
package pong_pkg;

    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_t;

    localparam int BALL_W = 7;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: saturating BCD score with a binary shadow for threshold compares
module bcd_score_counter
    import pong_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int W      = clog2(10 ** DIGITS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                inc,
    output logic [DIGITS*4-1:0] bcd,
    output logic [W-1:0]        bin,
    output logic [W-1:0]        bin_next
);

    localparam int MAX = 10 ** DIGITS - 1;

    logic                sat;
    logic                carry;
    logic [DIGITS*4-1:0] bcd_inc;

    assign sat      = bin == W'(MAX);
    assign bin_next = sat ? bin : bin + W'(1);

    // ripple +1 through the digits; a 9 wraps to 0 and carries into the next digit
    always_comb begin
        bcd_inc = bcd;
        carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                carry                = bcd[i*4 +: 4] == 4'd9;
                bcd_inc[i*4 +: 4]    = carry ? 4'd0 : bcd[i*4 +: 4] + 4'd1;
            end
        end
    end

    // score register: clear beats increment, and a full counter stays put
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd <= '0;
            bin <= '0;
        end else if (clr) begin
            bcd <= '0;
            bin <= '0;
        end else if (inc && !sat) begin
            bcd <= bcd_inc;
            bin <= bin_next;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-flow FSMD tracking scores, ball budget, wait timer and the winner
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int DIGITS      = 2,
    parameter int BALLS       = 7,
    parameter int WIN_SCORE   = 11,
    parameter int WAIT_TICKS  = 120,
    parameter int OVER_TICKS  = 180
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            frame_tick,
    input  logic                            start,
    input  logic [NUM_PLAYERS-1:0]          pts,
    output logic                            gra_still,
    output logic [1:0]                      state,
    output logic [BALL_W-1:0]               balls_left,
    output logic [NUM_PLAYERS*DIGITS*4-1:0] scores_bcd,
    output logic [NUM_PLAYERS-1:0]          winner,
    output logic                            timer_busy
);

    localparam int W  = clog2(10 ** DIGITS);
    localparam int TW = clog2((WAIT_TICKS > OVER_TICKS ? WAIT_TICKS : OVER_TICKS) + 2);

    state_t                           st;
    logic [TW-1:0]                    timer;
    logic                             timer_up;
    logic                             clr;
    logic                             won;
    logic [2:0]                       ties;
    logic [W-1:0]                     best;
    logic [NUM_PLAYERS-1:0]           sel;
    logic [NUM_PLAYERS-1:0]           inc;
    logic [NUM_PLAYERS-1:0]           win_hit;
    logic [NUM_PLAYERS-1:0]           lead;
    logic [NUM_PLAYERS-1:0][W-1:0]    bin;
    logic [NUM_PLAYERS-1:0][W-1:0]    bin_next;
    logic [NUM_PLAYERS-1:0][W-1:0]    score_new;

    assign state      = st;
    assign timer_up   = timer == '0;
    assign timer_busy = !timer_up;
    assign gra_still  = st != PLAY;
    assign sel        = pts & (~pts + NUM_PLAYERS'(1));
    assign inc        = sel & {NUM_PLAYERS{st == PLAY}};
    assign clr        = st == NEWGAME || (st == OVER && timer_up);
    assign won        = WIN_SCORE != 0 && |(sel & win_hit);

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
        bcd_score_counter #(.DIGITS(DIGITS)) u_score (
            .clk      (clk),
            .reset    (reset),
            .clr      (clr),
            .inc      (inc[g]),
            .bcd      (scores_bcd[g*DIGITS*4 +: DIGITS*4]),
            .bin      (bin[g]),
            .bin_next (bin_next[g])
        );
    end

    // scores as they will stand after this point, win-score hits, and the unique leader
    always_comb begin
        score_new = '0;
        win_hit   = '0;
        best      = '0;
        lead      = '0;
        ties      = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            score_new[i] = sel[i] ? bin_next[i] : bin[i];
            win_hit[i]   = bin_next[i] == W'(WIN_SCORE);
            if (score_new[i] > best) begin
                best = score_new[i];
                lead = NUM_PLAYERS'(1) << i;
            end
        end
        for (int i = 0; i < NUM_PLAYERS; i++) ties = ties + 3'(score_new[i] == best);
    end

    // game flow; a timer load on state entry overrides the frame-tick decrement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= NEWGAME;
            balls_left <= BALL_W'(BALLS);
            winner     <= '0;
            timer      <= '0;
        end else begin
            if (frame_tick && !timer_up) timer <= timer - TW'(1);
            case (st)
                NEWGAME: begin
                    balls_left <= BALL_W'(start ? BALLS - 1 : BALLS);
                    winner     <= '0;
                    if (start) st <= PLAY;
                end
                PLAY: if (|pts) begin
                    if (won || balls_left == '0) begin
                        st     <= OVER;
                        winner <= won ? sel : (ties == 3'd1 ? lead : '0);
                        timer  <= TW'(OVER_TICKS);
                    end else begin
                        st    <= NEWBALL;
                        timer <= TW'(WAIT_TICKS);
                    end
                end
                NEWBALL: if (timer_up && start) begin
                    st <= PLAY;
                    if (balls_left != '0) balls_left <= balls_left - BALL_W'(1);
                end
                OVER: if (timer_up) begin
                    st         <= NEWGAME;
                    balls_left <= BALL_W'(BALLS);
                    winner     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: scoreboard bench driving four differently-parameterised controllers
module tb_pong_game_ctrl;

    localparam int N = 4;

    typedef struct {
        string       tag;
        int          inst;
        logic [28:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start_v [N];
    logic [1:0] pts_v [N];
    logic       gra_v [N];
    logic       busy_v [N];
    logic [1:0] st_v [N];
    logic [1:0] win_v [N];
    logic [6:0] bl_v [N];
    logic [15:0] sc0, sc1;
    logic [7:0]  sc2, sc3;
    int         balls_of [N] = '{7, 20, 2, 13};
    exp_t       sb [$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    pong_game_ctrl u0 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start_v[0]), .pts(pts_v[0]),
        .gra_still(gra_v[0]), .state(st_v[0]), .balls_left(bl_v[0]), .scores_bcd(sc0),
        .winner(win_v[0]), .timer_busy(busy_v[0]));

    pong_game_ctrl #(.BALLS(20), .WAIT_TICKS(2), .OVER_TICKS(4)) u1 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start_v[1]), .pts(pts_v[1]),
        .gra_still(gra_v[1]), .state(st_v[1]), .balls_left(bl_v[1]), .scores_bcd(sc1),
        .winner(win_v[1]), .timer_busy(busy_v[1]));

    pong_game_ctrl #(.DIGITS(1), .BALLS(2), .WIN_SCORE(0), .WAIT_TICKS(2), .OVER_TICKS(4)) u2 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start_v[2]), .pts(pts_v[2]),
        .gra_still(gra_v[2]), .state(st_v[2]), .balls_left(bl_v[2]), .scores_bcd(sc2),
        .winner(win_v[2]), .timer_busy(busy_v[2]));

    pong_game_ctrl #(.DIGITS(1), .BALLS(13), .WIN_SCORE(0), .WAIT_TICKS(2), .OVER_TICKS(4)) u3 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start_v[3]), .pts(pts_v[3]),
        .gra_still(gra_v[3]), .state(st_v[3]), .balls_left(bl_v[3]), .scores_bcd(sc3),
        .winner(win_v[3]), .timer_busy(busy_v[3]));

    function automatic logic [28:0] obs(input int i);
        logic [15:0] sc;
        sc = i == 0 ? sc0 : i == 1 ? sc1 : i == 2 ? {8'h00, sc2} : {8'h00, sc3};
        return {st_v[i], bl_v[i], sc, win_v[i], gra_v[i], busy_v[i]};
    endfunction

    function automatic logic [15:0] bcd2(input int n);
        return 16'((n / 10) * 16 + n % 10);
    endfunction

    task automatic chk(input string tag, input logic [28:0] got, input logic [28:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got st/bl/sc/win/gra/busy=%h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int i, input logic [1:0] st, input int bl,
                              input logic [15:0] sc, input logic [1:0] win, input logic busy);
        sb.push_back('{tag, i, {st, 7'(bl), sc, win, st != 2'b01, busy}});
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, obs(e.inst), e.val);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic drive(input int i, input logic s, input logic [1:0] p, input logic ft);
        start_v[i] = s;
        pts_v[i]   = p;
        frame_tick = ft;
    endtask

    task automatic rally(input int i, input int wt, input logic [1:0] p, input string tag,
                         input logic [1:0] st, input int bl, input logic [15:0] sc,
                         input logic [1:0] win, input logic busy);
        repeat (wt) begin
            drive(i, 1'b1, 2'b00, 1'b1);
            cyc();
        end
        drive(i, 1'b1, 2'b00, 1'b0);
        cyc();
        drive(i, 1'b0, p, 1'b0);
        expect_out(tag, i, st, bl, sc, win, busy);
        cyc();
        drive(i, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic finish_game(input int i, input int ot, input logic [1:0] win,
                               input logic [15:0] sc, input int bl);
        repeat (ot - 1) begin
            drive(i, 1'b0, 2'b00, 1'b1);
            cyc();
        end
        drive(i, 1'b1, 2'b11, 1'b1);
        expect_out("over_hold", i, 2'b11, bl, sc, win, 1'b0);
        cyc();
        drive(i, 1'b1, 2'b11, 1'b0);
        expect_out("over_exit", i, 2'b00, balls_of[i], 16'h0000, 2'b00, 1'b0);
        cyc();
        drive(i, 1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            start_v[i] = 1'b0;
            pts_v[i]   = 2'b00;
        end
        #2 reset = 1'b1;
        #20 reset = 1'b0;
        #1;
        for (int i = 0; i < N; i++) expect_out("reset", i, 2'b00, balls_of[i], 16'h0000, 2'b00, 1'b0);
        drain();
        // default controller: single-point flow, wait timer, simultaneous points, exhaustion
        drive(0, 1'b1, 2'b00, 1'b0);
        expect_out("start", 0, 2'b01, 6, 16'h0000, 2'b00, 1'b0);
        cyc();
        drive(0, 1'b0, 2'b10, 1'b0);
        expect_out("p1_point", 0, 2'b10, 6, 16'h0100, 2'b00, 1'b1);
        cyc();
        drive(0, 1'b1, 2'b00, 1'b1);
        repeat (118) cyc();
        expect_out("nb_hold", 0, 2'b10, 6, 16'h0100, 2'b00, 1'b1);
        cyc();
        expect_out("nb_expire", 0, 2'b10, 6, 16'h0100, 2'b00, 1'b0);
        cyc();
        drive(0, 1'b1, 2'b00, 1'b0);
        expect_out("restart", 0, 2'b01, 5, 16'h0100, 2'b00, 1'b0);
        cyc();
        drive(0, 1'b0, 2'b11, 1'b0);
        expect_out("both_pts", 0, 2'b10, 5, 16'h0101, 2'b00, 1'b1);
        cyc();
        drive(0, 1'b0, 2'b00, 1'b0);
        for (int k = 0; k < 4; k++) rally(0, 120, 2'b01, "p0_rally", 2'b10, 4 - k, 16'h0102 + 16'(k), 2'b00, 1'b1);
        rally(0, 120, 2'b01, "exhaust_lead", 2'b11, 0, 16'h0106, 2'b01, 1'b1);
        finish_game(0, 180, 2'b01, 16'h0106, 0);
        // win score reached before the ball budget runs out
        drive(1, 1'b1, 2'b00, 1'b0);
        expect_out("w_start", 1, 2'b01, 19, 16'h0000, 2'b00, 1'b0);
        cyc();
        drive(1, 1'b0, 2'b11, 1'b0);
        expect_out("w_simul", 1, 2'b10, 19, 16'h0001, 2'b00, 1'b1);
        cyc();
        drive(1, 1'b0, 2'b00, 1'b0);
        for (int k = 0; k < 9; k++) rally(1, 2, 2'b01, "w_count", 2'b10, 18 - k, bcd2(k + 2), 2'b00, 1'b1);
        rally(1, 2, 2'b01, "w_win", 2'b11, 9, 16'h0011, 2'b01, 1'b1);
        finish_game(1, 4, 2'b01, 16'h0011, 9);
        // two balls, one point each: tie on exhaustion
        drive(2, 1'b1, 2'b00, 1'b0);
        expect_out("t_start", 2, 2'b01, 1, 16'h0000, 2'b00, 1'b0);
        cyc();
        drive(2, 1'b0, 2'b01, 1'b0);
        expect_out("t_p0", 2, 2'b10, 1, 16'h0001, 2'b00, 1'b1);
        cyc();
        drive(2, 1'b0, 2'b00, 1'b0);
        rally(2, 2, 2'b10, "t_tie", 2'b11, 0, 16'h0011, 2'b00, 1'b1);
        finish_game(2, 4, 2'b00, 16'h0011, 0);
        // single digit saturates at 9, then reset lands mid-NEWBALL
        drive(3, 1'b1, 2'b00, 1'b0);
        expect_out("s_start", 3, 2'b01, 12, 16'h0000, 2'b00, 1'b0);
        cyc();
        drive(3, 1'b0, 2'b01, 1'b0);
        expect_out("s_p0", 3, 2'b10, 12, 16'h0001, 2'b00, 1'b1);
        cyc();
        drive(3, 1'b0, 2'b00, 1'b0);
        for (int k = 2; k <= 12; k++) rally(3, 2, 2'b01, "s_sat", 2'b10, 13 - k, 16'(k > 9 ? 9 : k), 2'b00, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int i = 0; i < N; i++) expect_out("async_rst", i, 2'b00, balls_of[i], 16'h0000, 2'b00, 1'b0);
        drain();
        #10 reset = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
